// File: rtl/status_msg_display.sv
// Error-status display for a bank of 7-segment digits: dashes when idle, then "Error"
// either blinked a fixed number of times and held, or scrolled circularly.
module status_msg_display #(
    parameter int NUM_DIGITS  = 5,
    parameter int BLINK_DIV   = 25000000,
    parameter int BLINK_COUNT = 3,
    parameter int SCROLL_DIV  = 12500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    err_set,
    input  logic                    err_clr,
    input  logic                    scroll_en,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    err_active
);

    localparam int MSG_LEN = 5 + NUM_DIGITS;
    localparam int DIV_MAX = (BLINK_DIV > SCROLL_DIV) ? BLINK_DIV : SCROLL_DIV;
    localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int PW      = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;
    localparam int OW      = $clog2(MSG_LEN);

    localparam logic [CW-1:0] BLINK_LAST  = CW'(BLINK_DIV - 1);
    localparam logic [CW-1:0] SCROLL_LAST = CW'(SCROLL_DIV - 1);
    localparam logic [PW-1:0] PAIR_LAST   = PW'(BLINK_COUNT - 1);
    localparam logic [OW-1:0] OFFSET_LAST = OW'(MSG_LEN - 1);

    localparam logic [6:0] G_DASH  = 7'b1000000;
    localparam logic [6:0] G_E     = 7'b1111001;
    localparam logic [6:0] G_R     = 7'b1010000;
    localparam logic [6:0] G_O     = 7'b1011100;
    localparam logic [6:0] G_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLINK  = 2'd1,
        HOLD   = 2'd2,
        SCROLL = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   phase, phase_n;
    logic [PW-1:0]          pair, pair_n;
    logic [OW-1:0]          offset, offset_n;
    logic [7*NUM_DIGITS-1:0] seg_n;

    // Element idx of the circular message: "Error" followed by blanks.
    function automatic logic [6:0] msg_glyph(input int idx);
        case (idx)
            0:       msg_glyph = G_E;
            1:       msg_glyph = G_R;
            2:       msg_glyph = G_R;
            3:       msg_glyph = G_O;
            4:       msg_glyph = G_R;
            default: msg_glyph = G_BLANK;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            phase      <= 1'b0;
            pair       <= '0;
            offset     <= '0;
            seg        <= {NUM_DIGITS{G_DASH}};
            err_active <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            phase      <= phase_n;
            pair       <= pair_n;
            offset     <= offset_n;
            seg        <= seg_n;
            err_active <= (state != IDLE);
        end
    end

    // Clear beats set; set restarts from any state with a fresh scroll_en sample.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        phase_n  = phase;
        pair_n   = pair;
        offset_n = offset;
        if (err_clr || err_set) begin
            state_n  = err_clr ? IDLE : (scroll_en ? SCROLL : BLINK);
            cnt_n    = '0;
            phase_n  = 1'b0;
            pair_n   = '0;
            offset_n = '0;
        end else begin
            case (state)
                BLINK: begin
                    if (cnt == BLINK_LAST) begin
                        cnt_n = '0;
                        if (phase) begin
                            phase_n = 1'b0;
                            if (pair == PAIR_LAST) begin
                                state_n = HOLD;
                                pair_n  = '0;
                            end else begin
                                pair_n = pair + 1'b1;
                            end
                        end else begin
                            phase_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                SCROLL: begin
                    if (cnt == SCROLL_LAST) begin
                        cnt_n    = '0;
                        offset_n = (offset == OFFSET_LAST) ? '0 : offset + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        seg_n = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            int idx;
            idx = int'(offset) + NUM_DIGITS - 1 - k;
            if (idx >= MSG_LEN) idx = idx - MSG_LEN;
            case (state)
                IDLE:    seg_n[7*k +: 7] = G_DASH;
                BLINK:   seg_n[7*k +: 7] = phase ? G_BLANK : msg_glyph(NUM_DIGITS - 1 - k);
                HOLD:    seg_n[7*k +: 7] = msg_glyph(NUM_DIGITS - 1 - k);
                default: seg_n[7*k +: 7] = msg_glyph(idx);
            endcase
        end
    end

endmodule

// File: tb/tb_status_msg_display.sv
// Directed bench for status_msg_display with 6 digits, blink 4/2, scroll 3.
module tb_status_msg_display;

    localparam int ND = 6;

    localparam logic [6:0] DASH = 7'b1000000;
    localparam logic [6:0] GE   = 7'b1111001;
    localparam logic [6:0] GR   = 7'b1010000;
    localparam logic [6:0] GO   = 7'b1011100;
    localparam logic [6:0] BL   = 7'b0000000;

    localparam logic [41:0] DASHES = {DASH, DASH, DASH, DASH, DASH, DASH};
    localparam logic [41:0] WORD   = {GE, GR, GR, GO, GR, BL};
    localparam logic [41:0] BLANKS = 42'd0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err_set = 1'b0;
    logic        err_clr = 1'b0;
    logic        scroll_en = 1'b0;
    logic [41:0] seg;
    logic        err_active;

    int total = 0;
    int bad   = 0;

    status_msg_display #(
        .NUM_DIGITS(ND), .BLINK_DIV(4), .BLINK_COUNT(2), .SCROLL_DIV(3)
    ) dut (
        .clk(clk), .rst(rst), .err_set(err_set), .err_clr(err_clr),
        .scroll_en(scroll_en), .seg(seg), .err_active(err_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected scroll frame for a given offset: "Error" + six blanks, circular.
    function automatic logic [41:0] exp_scroll(input int off);
        logic [6:0] msg [11];
        logic [41:0] r;
        msg = '{GE, GR, GR, GO, GR, BL, BL, BL, BL, BL, BL};
        r = '0;
        for (int k = 0; k < ND; k++) r[7*k +: 7] = msg[(off + ND - 1 - k) % 11];
        return r;
    endfunction

    task automatic pulse_set(input logic mode);
        err_set = 1'b1; scroll_en = mode;
        tick();
        err_set = 1'b0; scroll_en = ~mode;
    endtask

    task automatic test_reset();
        rst = 1'b1; err_set = 1'b1; scroll_en = 1'b1;
        tick(); tick();
        rst = 1'b0; err_set = 1'b0; scroll_en = 1'b0;
        total++;
        if (seg !== DASHES) begin
            bad++; $display("FAIL reset_seg got=%h want=%h", seg, DASHES);
        end
        total++;
        if (err_active !== 1'b0) begin
            bad++; $display("FAIL reset_active got=%b want=0", err_active);
        end
    endtask

    task automatic test_blink();
        logic [41:0] want;
        pulse_set(1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            want = (i <= 16 && ((i - 1) / 4) % 2 == 1) ? BLANKS : WORD;
            total++;
            if (seg !== want) begin
                bad++; $display("FAIL blink_seg i=%0d got=%h want=%h", i, seg, want);
            end
            total++;
            if (err_active !== 1'b1) begin
                bad++; $display("FAIL blink_active i=%0d got=%b want=1", i, err_active);
            end
        end
    endtask

    task automatic test_clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
        total++;
        if (seg !== DASHES || err_active !== 1'b0) begin
            bad++; $display("FAIL clear got=%h/%b want=%h/0", seg, err_active, DASHES);
        end
    endtask

    task automatic test_set_clr_idle();
        err_set = 1'b1; err_clr = 1'b1; scroll_en = 1'b0;
        tick();
        err_set = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (seg !== DASHES || err_active !== 1'b0) begin
                bad++; $display("FAIL set_clr_idle i=%0d got=%h/%b want=%h/0", i, seg, err_active, DASHES);
            end
        end
    endtask

    task automatic test_scroll();
        logic [41:0] want;
        pulse_set(1'b1);
        for (int i = 1; i <= 36; i++) begin
            tick();
            want = exp_scroll(((i - 1) / 3) % 11);
            total++;
            if (seg !== want || err_active !== 1'b1) begin
                bad++; $display("FAIL scroll i=%0d got=%h/%b want=%h/1", i, seg, err_active, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [41:0] want;
        pulse_set(1'b0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            want = (i <= 4) ? WORD : BLANKS;
            total++;
            if (seg !== want) begin
                bad++; $display("FAIL restart_blink i=%0d got=%h want=%h", i, seg, want);
            end
        end
    endtask

    task automatic test_hold_to_scroll();
        test_clear();
        pulse_set(1'b0);
        for (int i = 0; i < 18; i++) tick();
        total++;
        if (seg !== WORD) begin
            bad++; $display("FAIL hold_word got=%h want=%h", seg, WORD);
        end
        err_set = 1'b1; scroll_en = 1'b1;
        tick();
        err_set = 1'b0; scroll_en = 1'b0;
        tick();
        total++;
        if (seg !== exp_scroll(0) || err_active !== 1'b1) begin
            bad++; $display("FAIL hold_scroll got=%h/%b want=%h/1", seg, err_active, exp_scroll(0));
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (err_active !== 1'b1) begin
            bad++; $display("FAIL clr_latency got=%b want=1", err_active);
        end
        tick();
        total++;
        if (seg !== DASHES || err_active !== 1'b0) begin
            bad++; $display("FAIL scroll_clr got=%h/%b want=%h/0", seg, err_active, DASHES);
        end
    endtask

    task automatic test_rst_mid_blink();
        pulse_set(1'b0);
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (seg !== BLANKS) begin
            bad++; $display("FAIL mid_blink_off got=%h want=%h", seg, BLANKS);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (seg !== DASHES || err_active !== 1'b0) begin
            bad++; $display("FAIL rst_mid_blink got=%h/%b want=%h/0", seg, err_active, DASHES);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (seg !== DASHES || err_active !== 1'b0) begin
                bad++; $display("FAIL post_rst i=%0d got=%h/%b want=%h/0", i, seg, err_active, DASHES);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_clear();
        test_set_clr_idle();
        test_scroll();
        test_back_to_back();
        test_hold_to_scroll();
        test_rst_mid_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/status_msg_display.md
STATUS_MSG_DISPLAY -- requirements
Module: status_msg_display

Interface
REQ-001 Parameter NUM_DIGITS, default 5: number of 7-segment digits driven; SHALL be >= 5.
REQ-002 Parameter BLINK_DIV, default 25000000: clock cycles per blink half-period; SHALL be >= 1.
REQ-003 Parameter BLINK_COUNT, default 3: on/off blink pairs before steady hold; SHALL be >= 1.
REQ-004 Parameter SCROLL_DIV, default 12500000: clock cycles per scroll step; SHALL be >= 1.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 err_set  input  1  error request, sampled every edge.
REQ-009 err_clr  input  1  error acknowledge/clear, sampled every edge.
REQ-010 scroll_en  input  1  mode select, sampled only on the edge that accepts err_set: 0 = blink, 1 = scroll.
REQ-011 seg  output  7*NUM_DIGITS  registered segment bus; digit d at bits [7d+6:7d], bit order gfedcba, 1 = lit; digit NUM_DIGITS-1 is leftmost.
REQ-012 err_active  output  1  registered; 1 whenever state is not IDLE.

Function
REQ-013 Glyphs SHALL be: dash 1000000, E 1111001, r 1010000, o 1011100, blank 0000000.
REQ-014 Message word "Error" SHALL be E,r,r,o,r on digits NUM_DIGITS-1 down to NUM_DIGITS-5; remaining lower digits blank.
REQ-015 States SHALL be IDLE, BLINK, HOLD, SCROLL.
REQ-016 IDLE: every digit shows dash.
REQ-017 IDLE, err_set=1, err_clr=0: next state BLINK if scroll_en=0, else SCROLL; phase/step/pair counters cleared.
REQ-018 BLINK: starts in on phase (message word shown), toggles on/off every BLINK_DIV cycles; off phase shows all blank.
REQ-019 BLINK: at the end of the off phase of pair BLINK_COUNT, state SHALL become HOLD.
REQ-020 HOLD: message word shown steadily until err_clr or err_set.
REQ-021 SCROLL: circular message of length M = 5+NUM_DIGITS (E,r,r,o,r, then NUM_DIGITS blanks); leftmost digit shows element offset, digit k shows element (offset+NUM_DIGITS-1-k) mod M.
REQ-022 SCROLL: offset SHALL start at 0 on entry, increment every SCROLL_DIV cycles, wrap M-1 -> 0.
REQ-023 err_clr=1 in any state SHALL force IDLE next edge; err_clr has priority over simultaneous err_set.
REQ-024 err_set=1 (err_clr=0) in BLINK, HOLD or SCROLL SHALL restart: re-sample scroll_en, clear all counters, enter BLINK or SCROLL.
REQ-025 scroll_en changes outside an accepting edge SHALL have no effect.
REQ-026 Latency: state changes on edge N sampling the input; seg and err_active reflect the new state after edge N+1 (one register stage).
REQ-027 Counters SHALL be sized from parameters ($clog2) and never overflow; division counts exact (half-period = BLINK_DIV cycles exactly).

Reset
REQ-028 rst=1 at an edge SHALL set state IDLE, all counters 0, offset 0, regardless of state or other inputs.
REQ-029 One edge after reset: seg = all dashes, err_active = 0.
REQ-030 Reset mid-BLINK or mid-SCROLL SHALL abandon the sequence; no resumption after release.

Verification (NUM_DIGITS=6, BLINK_DIV=4, BLINK_COUNT=2, SCROLL_DIV=3)
REQ-031 Reset for 2 cycles -> seg = six dashes (1000000 each), err_active 0.
REQ-032 err_set pulse, scroll_en=0 -> seg digits 5..1 = E,r,r,o,r, digit 0 blank for 4 cycles, all blank 4 cycles, repeat once, then steady word; err_active 1 throughout.
REQ-033 err_set pulse, scroll_en=1 -> leftmost digit sequence E,r,r,o,r,blank x6,E... changing every 3 cycles; offset wraps after 11 steps (33 cycles).
REQ-034 err_set and err_clr high same edge while IDLE -> stays IDLE, seg remains dashes.
REQ-035 In HOLD, err_set with scroll_en=1 -> SCROLL with offset 0 (word left-aligned) two edges later; then err_clr -> dashes two edges later.
REQ-036 rst asserted mid-BLINK off phase -> dashes after next edge, err_active 0, no blinking after release.
